// File: rtl/my_register_arbiter.sv
// my_register_arbiter: round-robin shared write register with bounded lock ownership
module my_register_arbiter #(
  parameter int WIDTH = 16,
  parameter int NUM_REQ = 4,
  parameter logic [WIDTH-1:0] INIT = '0,
  parameter int MAX_LOCK = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESETN,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_lock,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         O,
  output logic [IW-1:0]            grant_id,
  output logic                     locked,
  output logic [15:0]              wr_count
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, grant_id_q, grant_id_d, win, idx;
  logic [IW:0] sum;
  logic [7:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic found, accept;
  always_comb begin
    win = owner_q;
    found = 1'b0;
    sum = '0;
    idx = '0;
    if (state_q == IDLE) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        sum = {1'b0, ptr_q} + (IW+1)'(k);
        idx = sum >= (IW+1)'(NUM_REQ) ? IW'(sum - (IW+1)'(NUM_REQ)) : IW'(sum);
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          win = idx;
        end
      end
    end else begin
      found = req_valid[owner_q];
    end
    accept = found && ASYNCRESETN;
    req_ready = accept ? NUM_REQ'(1) << win : '0;
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    o_d = accept ? req_data[int'(win)*WIDTH +: WIDTH] : o_q;
    grant_id_d = accept ? win : grant_id_q;
    wr_count_d = accept ? wr_count_q + 16'd1 : wr_count_q;
    if (state_q == IDLE) begin
      ptr_d = accept ? win : ptr_q;
      if (accept && req_lock[win] && MAX_LOCK > 1) begin
        state_d = LOCKED;
        owner_d = win;
        cnt_d = 8'(MAX_LOCK - 1);
      end
    end else begin
      cnt_d = cnt_q - 8'd1;
      state_d = (accept && !req_lock[owner_q]) || cnt_q == 8'd0 ? IDLE : LOCKED;
    end
  end
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= IDLE;
      ptr_q <= IW'(NUM_REQ - 1);
      owner_q <= '0;
      cnt_q <= '0;
      o_q <= INIT;
      grant_id_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      o_q <= o_d;
      grant_id_q <= grant_id_d;
      wr_count_q <= wr_count_d;
    end
  end
  assign O = o_q;
  assign grant_id = grant_id_q;
  assign locked = state_q == LOCKED;
  assign wr_count = wr_count_q;
endmodule

// File: tb/tb_my_register_arbiter.sv
// tb_my_register_arbiter: randomized and directed checks against a cycle-level reference model
module tb_my_register_arbiter;
  localparam int W = 16, N = 4, ML = 4;
  localparam logic [W-1:0] INIT = 16'h0000;
  logic CLK = 0, ASYNCRESETN = 0;
  logic [N-1:0] req_valid = '0, req_lock = '0, req_ready;
  logic [N*W-1:0] req_data = '0;
  logic [W-1:0] O;
  logic [1:0] grant_id;
  logic locked;
  logic [15:0] wr_count;
  int n_cmp = 0, n_bad = 0;
  int m_ptr, m_owner, m_left, m_gid;
  bit m_lk;
  logic [W-1:0] m_o;
  logic [15:0] m_wc;
  always #5 CLK = ~CLK;
  my_register_arbiter #(.WIDTH(W), .NUM_REQ(N), .INIT(INIT), .MAX_LOCK(ML)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .req_valid(req_valid), .req_lock(req_lock),
    .req_data(req_data), .req_ready(req_ready), .O(O), .grant_id(grant_id),
    .locked(locked), .wr_count(wr_count)
  );
  function automatic logic [N-1:0] m_grant();
    logic [N-1:0] one;
    one = 1;
    if (!ASYNCRESETN) return '0;
    if (m_lk) return req_valid[m_owner] ? one << m_owner : '0;
    for (int k = 1; k <= N; k++)
      if (req_valid[(m_ptr + k) % N]) return one << ((m_ptr + k) % N);
    return '0;
  endfunction
  function automatic logic [N+W+2+1+16-1:0] m_view();
    return {m_grant(), m_o, 2'(m_gid), m_lk, m_wc};
  endfunction
  task automatic m_reset();
    m_ptr = N - 1; m_lk = 0; m_owner = 0; m_left = 0; m_gid = 0; m_o = INIT; m_wc = 0;
  endtask
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N*W-1:0] d);
    req_valid = v; req_lock = l; req_data = d;
    #2;
  endtask
  task automatic tick();
    logic [N-1:0] g;
    logic [W-1:0] d;
    bit lk;
    int w;
    g = m_grant();
    w = 0;
    for (int i = 0; i < N; i++) if (g[i]) w = i;
    d = req_data[w*W +: W];
    lk = req_lock[w];
    @(posedge CLK);
    #1;
    if (g != 0) begin m_o = d; m_gid = w; m_wc++; end
    if (m_lk) begin
      m_left--;
      if ((g != 0 && !lk) || m_left == 0) m_lk = 0;
    end else if (g != 0) begin
      m_ptr = w;
      if (lk && ML > 1) begin m_lk = 1; m_owner = w; m_left = ML; end
    end
  endtask
  task automatic test_reset();
    @(posedge CLK); #1;
    ASYNCRESETN = 0;
    m_reset();
    drive(4'hF, 4'h0, {4{16'h7777}});
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
    @(posedge CLK); #1;
    ASYNCRESETN = 1;
    for (int c = 0; c < 3; c++) begin
      drive(4'h0, 4'h0, '0);
      n_cmp++; if ({req_ready, O, grant_id, locked, wr_count} !== m_view()) begin n_bad++;
        $display("FAIL reset_idle c%0d: got ready=%b O=%h gid=%0d lk=%b wc=%0d exp ready=%b O=%h gid=%0d lk=%b wc=%0d", c, req_ready, O, grant_id, locked, wr_count, m_grant(), m_o, m_gid, m_lk, m_wc); end
      n_cmp++; if ({O, wr_count, locked} !== {INIT, 16'd0, 1'b0}) begin n_bad++;
        $display("FAIL reset_vals c%0d: got O=%h wc=%0d lk=%b exp O=%h wc=0 lk=0", c, O, wr_count, locked, INIT); end
      tick();
    end
  endtask
  task automatic test_round_robin();
    logic [N-1:0] exp;
    for (int c = 0; c < 8; c++) begin
      drive(4'hF, 4'h0, {16'hA003, 16'hA002, 16'hA001, 16'hA000});
      exp = 4'b0001 << (c % 4);
      n_cmp++; if (req_ready !== exp) begin n_bad++; $display("FAIL rr_grant c%0d: got %b exp %b", c, req_ready, exp); end
      n_cmp++; if ({req_ready, O, grant_id, locked, wr_count} !== m_view()) begin n_bad++;
        $display("FAIL rr_state c%0d: got ready=%b O=%h gid=%0d lk=%b wc=%0d exp ready=%b O=%h gid=%0d lk=%b wc=%0d", c, req_ready, O, grant_id, locked, wr_count, m_grant(), m_o, m_gid, m_lk, m_wc); end
      tick();
    end
    n_cmp++; if ({wr_count, O} !== {16'd8, 16'hA003}) begin n_bad++; $display("FAIL rr_end: got wc=%0d O=%h exp wc=8 O=a003", wr_count, O); end
  endtask
  task automatic test_lock();
    drive(4'b0010, 4'b0000, {4{16'h1111}});
    tick();
    drive(4'b0111, 4'b0100, {16'h0, 16'h1234, 16'h2222, 16'h3333});
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL lock_win: got %b exp 0100", req_ready); end
    tick();
    for (int c = 0; c < ML; c++) begin
      drive(4'b0111, 4'b0100, {$urandom, $urandom});
      n_cmp++; if ({req_ready, locked} !== {4'b0100, 1'b1}) begin n_bad++; $display("FAIL lock_hold c%0d: got ready=%b lk=%b exp 0100 1", c, req_ready, locked); end
      n_cmp++; if ({req_ready, O, grant_id, locked, wr_count} !== m_view()) begin n_bad++;
        $display("FAIL lock_state c%0d: got ready=%b O=%h gid=%0d lk=%b wc=%0d exp ready=%b O=%h gid=%0d lk=%b wc=%0d", c, req_ready, O, grant_id, locked, wr_count, m_grant(), m_o, m_gid, m_lk, m_wc); end
      tick();
    end
    drive(4'b0011, 4'b0000, {$urandom, $urandom});
    n_cmp++; if ({req_ready, locked} !== {4'b0001, 1'b0}) begin n_bad++; $display("FAIL lock_after: got ready=%b lk=%b exp 0001 0", req_ready, locked); end
    tick();
  endtask
  task automatic test_lock_idle();
    drive(4'b0010, 4'b0010, {16'h0, 16'h0, 16'hBEEF, 16'h0});
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL idle_win: got %b exp 0010", req_ready); end
    tick();
    for (int c = 0; c < ML; c++) begin
      drive(4'b1000, 4'b0000, {$urandom, $urandom});
      n_cmp++; if ({req_ready, locked, O} !== {4'b0000, 1'b1, 16'hBEEF}) begin n_bad++; $display("FAIL idle_hold c%0d: got ready=%b lk=%b O=%h exp 0000 1 beef", c, req_ready, locked, O); end
      tick();
    end
    drive(4'b1000, 4'b0000, {16'hC333, 48'h0});
    n_cmp++; if ({req_ready, locked} !== {4'b1000, 1'b0}) begin n_bad++; $display("FAIL idle_release: got ready=%b lk=%b exp 1000 0", req_ready, locked); end
    tick();
  endtask
  task automatic test_wrap();
    drive(4'b0001, 4'b0000, {48'h0, 16'h1357});
    for (int i = 0; i < 70000 && m_wc != 16'hFFFF; i++) tick();
    n_cmp++; if (wr_count !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_pre: got wc=%h exp ffff", wr_count); end
    drive(4'b0001, 4'b0000, {48'h0, 16'h5A5A});
    tick();
    n_cmp++; if ({wr_count, O} !== {16'h0000, 16'h5A5A}) begin n_bad++; $display("FAIL wrap: got wc=%h O=%h exp wc=0000 O=5a5a", wr_count, O); end
  endtask
  task automatic test_async_reset();
    drive(4'b0100, 4'b0100, {16'h0, 16'hC0DE, 32'h0});
    tick();
    drive(4'b0100, 4'b0100, {16'h0, 16'hC0DF, 32'h0});
    tick();
    n_cmp++; if ({locked, O} !== {1'b1, 16'hC0DF}) begin n_bad++; $display("FAIL ar_pre: got lk=%b O=%h exp 1 c0df", locked, O); end
    #1 ASYNCRESETN = 0;
    #1;
    n_cmp++; if ({O, locked, req_ready, wr_count} !== {INIT, 1'b0, 4'b0000, 16'd0}) begin n_bad++;
      $display("FAIL ar_now: got O=%h lk=%b ready=%b wc=%0d exp O=%h lk=0 ready=0000 wc=0", O, locked, req_ready, wr_count, INIT); end
    m_reset();
    @(posedge CLK); #2;
    ASYNCRESETN = 1;
    drive(4'hF, 4'h0, {16'hD003, 16'hD002, 16'hD001, 16'hD000});
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL ar_prio: got %b exp 0001", req_ready); end
    tick();
    n_cmp++; if ({req_ready, O, grant_id, locked, wr_count} !== m_view()) begin n_bad++;
      $display("FAIL ar_post: got ready=%b O=%h gid=%0d lk=%b wc=%0d exp ready=%b O=%h gid=%0d lk=%b wc=%0d", req_ready, O, grant_id, locked, wr_count, m_grant(), m_o, m_gid, m_lk, m_wc); end
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom & $urandom), {$urandom, $urandom});
      n_cmp++; if ({req_ready, O, grant_id, locked, wr_count} !== m_view()) begin n_bad++;
        $display("FAIL rand c%0d: got ready=%b O=%h gid=%0d lk=%b wc=%0d exp ready=%b O=%h gid=%0d lk=%b wc=%0d", c, req_ready, O, grant_id, locked, wr_count, m_grant(), m_o, m_gid, m_lk, m_wc); end
      n_cmp++; if (!$onehot0(req_ready) || (req_ready & ~req_valid) != 0) begin n_bad++;
        $display("FAIL rand_onehot c%0d: got ready=%b valid=%b exp one-hot subset", c, req_ready, req_valid); end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_lock_idle();
    test_random();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
